// File: rtl/novena_clk_monitor_pkg.sv
// Shared types and default timing constants for the gclk supervisor.
// Defaults assume a 50 MHz gclk sampled by a 200 MHz sys_clk (nominal distance 4).
package novena_clk_monitor_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        HOLD    = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int DEF_PERIOD_MIN = 3;
    localparam int DEF_PERIOD_MAX = 5;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/novena_sync_ff.sv
// N-stage flop synchronizer with asynchronous active-high reset to RST_VAL.
module novena_sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/novena_clk_monitor.sv
// Watches gclk from the sys_clk side: measures edge distance, detects loss,
// off-frequency and MCU reset, and drives a stretched reset request.
//   state   | meaning
//   ACQUIRE | waiting for LOCK_EDGES consecutive good gclk periods
//   HOLD    | gclk good, stretching reset for HOLD_CYCLES
//   LOCKED  | gclk trusted, clk_ok high
module novena_clk_monitor
    import novena_clk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX  = DEF_PERIOD_MAX,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_EDGES  = 8,
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 8,
    parameter int LOSS_W      = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              gclk_in,
    input  logic              reset_mcu_b,
    output logic              clk_ok,
    output logic              rst_req,
    output logic              clk_lost,
    output logic [CNT_W-1:0]  last_period,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  TIMER_MAX = '1;
    localparam logic [CNT_W-1:0]  P_MIN     = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0]  P_MAX     = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]  P_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_EDGES);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

    logic              gclk_s;
    logic              mcu_rst_b_s;
    logic              mcu_rst;
    logic              gclk_prev;
    logic              rise;
    logic [CNT_W-1:0]  timer;
    logic              ref_valid;
    logic              in_range;
    logic              good_edge;
    logic              bad_edge;
    logic              timeout;
    logic              fault;

    mon_state_t        state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              lost_nxt;
    logic [LOSS_W-1:0] loss_count_nxt;

    novena_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_gclk (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (gclk_in),
        .q   (gclk_s)
    );

    // Reset value 0 means the MCU is treated as in reset until proven otherwise.
    novena_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mcu_rst (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (reset_mcu_b),
        .q   (mcu_rst_b_s)
    );

    assign mcu_rst   = ~mcu_rst_b_s;
    assign rise      = gclk_s & ~gclk_prev;
    assign in_range  = (timer >= P_MIN) && (timer <= P_MAX);
    assign good_edge = rise & ref_valid & in_range;
    assign bad_edge  = rise & ref_valid & ~in_range;
    assign timeout   = ref_valid & ~rise & (timer == P_TIMEOUT);
    assign fault     = bad_edge | timeout;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gclk_prev   <= 1'b0;
            timer       <= '0;
            ref_valid   <= 1'b0;
            last_period <= '0;
        end else begin
            gclk_prev <= gclk_s;
            if (rise) begin
                timer <= CNT_W'(1);
            end else if (timer != TIMER_MAX) begin
                timer <= timer + CNT_W'(1);
            end
            if (mcu_rst) begin
                ref_valid <= 1'b0;
            end else if (rise) begin
                ref_valid <= 1'b1;
            end else if (timeout) begin
                ref_valid <= 1'b0;
            end
            if (rise && ref_valid && !mcu_rst) begin
                last_period <= timer;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        good_cnt_nxt   = good_cnt;
        hold_cnt_nxt   = hold_cnt;
        lost_nxt       = 1'b0;
        loss_count_nxt = loss_count;
        if (mcu_rst) begin
            state_nxt    = ACQUIRE;
            good_cnt_nxt = '0;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ACQUIRE: begin
                    if (fault) begin
                        good_cnt_nxt = '0;
                    end else if (good_edge) begin
                        if (good_cnt != GOOD_MAX) begin
                            good_cnt_nxt = good_cnt + GOOD_W'(1);
                        end
                        if (good_cnt_nxt >= GOOD_LOCK) begin
                            state_nxt    = HOLD;
                            good_cnt_nxt = '0;
                            hold_cnt_nxt = '0;
                        end
                    end
                end
                HOLD: begin
                    if (fault) begin
                        state_nxt    = ACQUIRE;
                        good_cnt_nxt = '0;
                        hold_cnt_nxt = '0;
                    end else begin
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
                        if (hold_cnt == HOLD_LAST) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (fault) begin
                        state_nxt    = ACQUIRE;
                        good_cnt_nxt = '0;
                        hold_cnt_nxt = '0;
                        lost_nxt     = 1'b1;
                        if (loss_count != '1) begin
                            loss_count_nxt = loss_count + LOSS_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs follow the next state so they flip in the same cycle as state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ACQUIRE;
            good_cnt   <= '0;
            hold_cnt   <= '0;
            clk_ok     <= 1'b0;
            rst_req    <= 1'b1;
            clk_lost   <= 1'b0;
            loss_count <= '0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            clk_ok     <= (state_nxt == LOCKED);
            rst_req    <= (state_nxt != LOCKED);
            clk_lost   <= lost_nxt;
            loss_count <= loss_count_nxt;
        end
    end

endmodule

// File: tb/tb_novena_clk_monitor.sv
// Directed bench for novena_clk_monitor: lock, stop, MCU reset, off-frequency,
// fault during HOLD, loss_count saturation (LOSS_W=2) and async sys_rst.
`timescale 1ns/1ps
module tb_novena_clk_monitor;

    localparam int CNT_W  = 8;
    localparam int LOSS_W = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              gclk_in;
    logic              reset_mcu_b;
    logic              clk_ok;
    logic              rst_req;
    logic              clk_lost;
    logic [CNT_W-1:0]  last_period;
    logic [LOSS_W-1:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    int gclk_period  = 20;
    bit gclk_run     = 1'b0;
    int stretch_req  = 0;
    int stretch_done = 0;
    int stretch_idx  = -1;

    int   lost_pulses = 0;
    int   rr_errs     = 0;
    int   since_rise  = 0;
    logic gclk_q      = 1'b0;

    novena_clk_monitor #(
        .SYNC_STAGES (2),
        .PERIOD_MIN  (3),
        .PERIOD_MAX  (5),
        .TIMEOUT     (16),
        .LOCK_EDGES  (8),
        .HOLD_CYCLES (64),
        .CNT_W       (CNT_W),
        .LOSS_W      (LOSS_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .gclk_in     (gclk_in),
        .reset_mcu_b (reset_mcu_b),
        .clk_ok      (clk_ok),
        .rst_req     (rst_req),
        .clk_lost    (clk_lost),
        .last_period (last_period),
        .loss_count  (loss_count)
    );

    always #2.5 sys_clk = ~sys_clk;

    // gclk source; a pending stretch request turns one period into 36 ns.
    initial begin : gclk_gen
        int idx;
        int per;
        idx     = 0;
        gclk_in = 1'b0;
        forever begin
            if (!gclk_run) begin
                gclk_in = 1'b0;
                idx     = 0;
                #1;
            end else begin
                per = gclk_period;
                if (stretch_req != stretch_done) begin
                    per          = 36;
                    stretch_done = stretch_done + 1;
                    stretch_idx  = idx;
                end
                gclk_in = 1'b1;
                #(per / 2);
                gclk_in = 1'b0;
                #(per - per / 2);
                idx = idx + 1;
            end
        end
    end

    // sys_clk edges since the last raw gclk rise (1 = first edge after it).
    always @(posedge sys_clk) begin
        gclk_q <= gclk_in;
        if (gclk_in && !gclk_q) since_rise <= 1;
        else                    since_rise <= since_rise + 1;
    end

    always @(negedge sys_clk) begin
        if (clk_lost === 1'b1) lost_pulses <= lost_pulses + 1;
        if (!sys_rst && (rst_req !== ~clk_ok)) rr_errs <= rr_errs + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (n < 500) begin
            @(posedge sys_clk); #1;
            n++;
            if (clk_ok) break;
        end
    endtask

    task automatic start_and_lock(input string tag);
        int n;
        @(negedge sys_clk);
        gclk_period = 20;
        gclk_run    = 1'b1;
        wait_lock(n);
        check_val({tag, "_lock_cycles"}, n, 99);
        check_val({tag, "_last_period"}, int'(last_period), 4);
        check_val({tag, "_rst_req"}, int'(rst_req), 0);
    endtask

    task automatic stop_clock(input string tag, input int exp_loss);
        int n;
        bit seen;
        @(negedge sys_clk);
        gclk_run = 1'b0;
        seen     = 1'b0;
        n        = 0;
        while (n < 200) begin
            @(posedge sys_clk); #1;
            n++;
            if (clk_lost) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_lost_seen"}, int'(seen), 1);
        check_val({tag, "_lost_delay"}, since_rise, 19);
        check_val({tag, "_loss_count"}, int'(loss_count), exp_loss);
        check_val({tag, "_rst_req"}, int'(rst_req), 1);
        repeat (200 - n) @(posedge sys_clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded, expected finish before 100000 ns", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int p0;
        bit seen_ok;

        reset_mcu_b = 1'b1;
        sys_rst     = 1'b1;
        #50;
        check_val("rst_clk_ok", int'(clk_ok), 0);
        check_val("rst_rst_req", int'(rst_req), 1);
        check_val("rst_clk_lost", int'(clk_lost), 0);
        check_val("rst_last_period", int'(last_period), 0);
        check_val("rst_loss_count", int'(loss_count), 0);
        #50;
        sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk);

        start_and_lock("lock1");
        stop_clock("stop1", 1);
        start_and_lock("relock1");

        // MCU reset while locked
        @(negedge sys_clk);
        p0          = lost_pulses;
        reset_mcu_b = 1'b0;
        n           = 0;
        while (n < 20) begin
            @(posedge sys_clk); #1;
            n++;
            if (rst_req) break;
        end
        check_val("mcu_rst_req_delay", n, 3);
        check_val("mcu_clk_ok", int'(clk_ok), 0);
        repeat (200) @(posedge sys_clk);
        #1;
        check_val("mcu_rst_req_held", int'(rst_req), 1);
        @(negedge sys_clk);
        reset_mcu_b = 1'b1;
        wait_lock(n);
        check_val("mcu_relock_window", int'(n >= 99 && n <= 102), 1);
        check_val("mcu_no_lost", lost_pulses, p0);
        check_val("mcu_loss_count", int'(loss_count), 1);

        stop_clock("stop2", 2);

        // Off-frequency: 40 ns period measures D=8
        @(negedge sys_clk);
        p0          = lost_pulses;
        gclk_period = 40;
        gclk_run    = 1'b1;
        seen_ok     = 1'b0;
        repeat (300) begin
            @(posedge sys_clk); #1;
            if (clk_ok) seen_ok = 1'b1;
        end
        check_val("offfreq_clk_ok_seen", int'(seen_ok), 0);
        check_val("offfreq_last_period", int'(last_period), 8);
        check_val("offfreq_rst_req", int'(rst_req), 1);
        check_val("offfreq_no_lost", lost_pulses, p0);
        @(negedge sys_clk);
        gclk_run = 1'b0;
        repeat (200) @(posedge sys_clk);

        // Fault during HOLD: period 15 is stretched to 36 ns
        @(negedge sys_clk);
        p0          = lost_pulses;
        gclk_period = 20;
        gclk_run    = 1'b1;
        n           = 0;
        while (n < 500) begin
            @(posedge sys_clk); #1;
            n++;
            if (n == 60) stretch_req = stretch_req + 1;
            if (clk_ok) break;
        end
        check_val("holdfault_stretch_idx", stretch_idx, 15);
        check_val("holdfault_lock_cycles", n, 166);
        check_val("holdfault_no_lost", lost_pulses, p0);
        check_val("holdfault_last_period", int'(last_period), 4);

        stop_clock("stop3", 3);
        start_and_lock("relock3");
        stop_clock("stop4", 3);
        start_and_lock("relock4");
        stop_clock("stop5", 3);
        start_and_lock("relock5");

        // Asynchronous sys_rst while locked
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_val("sysrst_clk_ok", int'(clk_ok), 0);
        check_val("sysrst_rst_req", int'(rst_req), 1);
        check_val("sysrst_clk_lost", int'(clk_lost), 0);
        check_val("sysrst_last_period", int'(last_period), 0);
        check_val("sysrst_loss_count", int'(loss_count), 0);
        #20;
        gclk_run = 1'b0;
        sys_rst  = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        check_val("post_rst_clk_ok", int'(clk_ok), 0);

        check_val("total_lost_pulses", lost_pulses, 5);
        check_val("rst_req_vs_clk_ok", rr_errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
